// File: rtl/seg_display_scanner.sv
// Time-multiplexed driver for a 4-digit 7-segment display.
// Inputs are captured into shadow registers once per frame so a frame never tears;
// each digit slot starts with a guard interval of dark anodes to suppress ghosting.
module seg_display_scanner #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned GUARD        = 4,
    parameter int unsigned BLINK_FRAMES = 125,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] num,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned DivW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    logic [DivW-1:0]   div_cnt_q, div_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic [15:0]       num_sh_q, num_sh_d;
    logic [3:0]        blink_sh_q, blink_sh_d;
    logic [3:0]        blank_sh_q, blank_sh_d;
    logic [3:0]        dp_sh_q, dp_sh_d;
    logic              frame_tick_q, frame_tick_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic       slot_end;
    logic       frame_end;
    logic [1:0] dsel;
    logic       dark;

    // BCD to segments, gfedcba; non-decimal codes blank the segments.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Next-state for scan counters, shadows, blink state and logical outputs.
    always_comb begin
        slot_end  = (div_cnt_q == DivW'(SCAN_DIV - 1));
        frame_end = slot_end && (idx_q == 2'd3);
        // idx 0 is the leftmost digit (3), so the digit number is the inverted index.
        dsel      = ~idx_q;
        dark      = blank_sh_q[dsel] | (blink_phase_q & blink_sh_q[dsel]);

        div_cnt_d     = slot_end ? '0 : div_cnt_q + DivW'(1);
        idx_d         = slot_end ? idx_q + 2'd1 : idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        num_sh_d      = num_sh_q;
        blink_sh_d    = blink_sh_q;
        blank_sh_d    = blank_sh_q;
        dp_sh_d       = dp_sh_q;
        frame_tick_d  = frame_end;

        if (frame_end) begin
            num_sh_d   = num;
            blink_sh_d = blink_mask;
            blank_sh_d = blank_mask;
            dp_sh_d    = dp_mask;
            if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BlinkW'(1);
            end
        end

        // Anode stays on for a dark digit; only segments and dp are suppressed.
        an_d  = (div_cnt_q < DivW'(GUARD)) ? 4'b0000 : (4'b0001 << dsel);
        seg_d = dark ? 7'b0000000 : bcd_to_seg(num_sh_q[{dsel, 2'b00} +: 4]);
        dp_d  = dark ? 1'b0 : dp_sh_q[dsel];
    end

    // State and registered logical outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt_q     <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            num_sh_q      <= '0;
            blink_sh_q    <= '0;
            blank_sh_q    <= '0;
            dp_sh_q       <= '0;
            frame_tick_q  <= 1'b0;
            an_q          <= '0;
            seg_q         <= '0;
            dp_q          <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            num_sh_q      <= num_sh_d;
            blink_sh_q    <= blink_sh_d;
            blank_sh_q    <= blank_sh_d;
            dp_sh_q       <= dp_sh_d;
            frame_tick_q  <= frame_tick_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    // Pin polarity applied after the output registers.
    assign an         = an_q ^ {4{ACTIVE_LOW}};
    assign seg        = seg_q ^ {7{ACTIVE_LOW}};
    assign dp         = dp_q ^ ACTIVE_LOW;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2.
// Timing reference: edge n is the n-th rising clk after resetn is released; the pins
// sampled after edge n reflect scan position n-1, so a frame is 16 edges long.
module tb_seg_display_scanner;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] num = '0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  an, an_l;
    logic [6:0]  seg, seg_l;
    logic        dp, dp_l;
    logic        ft, ft_l;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111, S4 = 7'b1100110, S5 = 7'b1101101;
    localparam logic [6:0] S6 = 7'b1111101, S7 = 7'b0000111, S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1101111, SOFF = 7'b0000000;

    seg_display_scanner #(
        .SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b0)
    ) u_dut (
        .clk(clk), .resetn(resetn), .num(num), .blink_mask(blink_mask),
        .blank_mask(blank_mask), .dp_mask(dp_mask), .an(an), .seg(seg), .dp(dp),
        .frame_tick(ft)
    );

    seg_display_scanner #(
        .SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)
    ) u_dut_l (
        .clk(clk), .resetn(resetn), .num(num), .blink_mask(blink_mask),
        .blank_mask(blank_mask), .dp_mask(dp_mask), .an(an_l), .seg(seg_l), .dp(dp_l),
        .frame_tick(ft_l)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to just after edge e.
    task automatic goto(input int e);
        while (cyc < e) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq({tag, " rst an"}, an, 4'b0000);
        check_eq({tag, " rst seg"}, seg, 7'h00);
        check_eq({tag, " rst ft"}, ft, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        cyc = 0;
    endtask

    // Guard then first active sample of slot s in frame f.
    task automatic check_slot(input string tag, input int f, input int s,
                              input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
        goto(16 * f + 4 * s + 1);
        check_eq({tag, " guard an"}, an, 4'b0000);
        goto(16 * f + 4 * s + 2);
        check_eq({tag, " an"}, an, e_an);
        check_eq({tag, " seg"}, seg, e_seg);
        check_eq({tag, " dp"}, dp, e_dp);
    endtask

    initial begin
        // Plain digits; first frame uses the zeroed shadows, active-low pins checked too.
        num = 16'h1234;
        do_reset("t1");
        check_eq("t5 rst an_l", an_l, 4'b1111);
        check_eq("t5 rst seg_l", seg_l, 7'h7F);
        check_eq("t5 rst dp_l", dp_l, 1'b1);
        check_slot("t1 f0d3", 0, 0, 4'b1000, S0, 1'b0);
        check_eq("t5 an_l", an_l, 4'b0111);
        check_eq("t5 seg_l", seg_l, 7'b1000000);
        check_eq("t5 dp_l", dp_l, 1'b1);
        goto(4);
        check_eq("t1 f0d3 last an", an, 4'b1000);
        check_slot("t1 f0d0", 0, 3, 4'b0001, S0, 1'b0);
        goto(15);
        check_eq("t1 ft pre", ft, 1'b0);
        goto(16);
        check_eq("t1 ft", ft, 1'b1);
        goto(17);
        check_eq("t1 ft post", ft, 1'b0);
        check_slot("t1 f1d3", 1, 0, 4'b1000, S1, 1'b0);
        check_slot("t1 f1d2", 1, 1, 4'b0100, S2, 1'b0);

        // Input change mid-slot of digit 2 must not reach this frame.
        goto(22);
        num = 16'h5678;
        check_slot("t2 f1d1", 1, 2, 4'b0010, S3, 1'b0);
        check_slot("t2 f1d0", 1, 3, 4'b0001, S4, 1'b0);
        check_slot("t2 f2d3", 2, 0, 4'b1000, S5, 1'b0);
        check_slot("t2 f2d2", 2, 1, 4'b0100, S6, 1'b0);
        check_slot("t2 f2d1", 2, 2, 4'b0010, S7, 1'b0);
        check_slot("t2 f2d0", 2, 3, 4'b0001, S8, 1'b0);

        // Blink on digits 1 and 0: frames 0-1 visible, 2-3 dark, 4-5 visible, 6-7 dark.
        num = 16'h1234;
        blink_mask = 4'b0011;
        do_reset("t3");
        check_slot("t3 f1d1", 1, 2, 4'b0010, S3, 1'b0);
        check_slot("t3 f1d0", 1, 3, 4'b0001, S4, 1'b0);
        check_slot("t3 f2d3", 2, 0, 4'b1000, S1, 1'b0);
        check_slot("t3 f2d1", 2, 2, 4'b0010, SOFF, 1'b0);
        check_slot("t3 f3d0", 3, 3, 4'b0001, SOFF, 1'b0);
        check_slot("t3 f4d1", 4, 2, 4'b0010, S3, 1'b0);
        check_slot("t3 f4d0", 4, 3, 4'b0001, S4, 1'b0);
        check_slot("t3 f6d2", 6, 1, 4'b0100, S2, 1'b0);
        check_slot("t3 f6d1", 6, 2, 4'b0010, SOFF, 1'b0);

        // Asynchronous reset in digit 1's slot of a dark blink frame.
        #2;
        resetn = 1'b0;
        #1;
        check_eq("t6 async an", an, 4'b0000);
        check_eq("t6 async seg", seg, 7'h00);
        check_eq("t6 async an_l", an_l, 4'b1111);
        @(negedge clk);
        resetn = 1'b1;
        cyc = 0;
        check_slot("t6 f0d3", 0, 0, 4'b1000, S0, 1'b0);
        check_slot("t6 f0d0", 0, 3, 4'b0001, S0, 1'b0);
        check_slot("t6 f1d0", 1, 3, 4'b0001, S4, 1'b0);

        // Blank, out-of-range codes and decimal point.
        num = 16'h9AF0;
        blink_mask = 4'b0000;
        blank_mask = 4'b0001;
        dp_mask = 4'b0100;
        do_reset("t4");
        check_slot("t4 f1d3", 1, 0, 4'b1000, S9, 1'b0);
        check_slot("t4 f1d2", 1, 1, 4'b0100, SOFF, 1'b1);
        check_slot("t4 f1d1", 1, 2, 4'b0010, SOFF, 1'b0);
        check_slot("t4 f1d0", 1, 3, 4'b0001, SOFF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
